frame_strobe_gen: RTL and testbench

FRAME_STROBE_GEN -- requirements
Module: frame_strobe_gen

---
 rtl/frame_cfg_pkg.sv | 19 +
 rtl/frame_strobe_gen_if.sv | 15 +
 rtl/cfg_phase_counter.sv | 32 +++
 rtl/frame_strobe_gen.sv | 136 +++++++++++++
 tb/tb_frame_strobe_gen.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/frame_cfg_pkg.sv
// Shared types and widths for the frame strobe generator and its phase timer.
package frame_cfg_pkg;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } fsm_state_e;

  // Phase counters count N-1 .. 0, so a phase of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] phase_load(input int cycles);
    int last;
    last = cycles - 1;
    return last[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/frame_strobe_gen_if.sv
// Frame write request channel: valid/ready handshake carrying column, frame index and data.
interface frame_strobe_gen_if
  import frame_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = 32
);
  logic                       s_valid;
  logic                       s_ready;
  logic [ADDR_W-1:0]          s_col;
  logic [ADDR_W-1:0]          s_frame;
  logic [FrameBitsPerRow-1:0] s_data;

  modport master (output s_valid, s_col, s_frame, s_data, input s_ready);
  modport slave  (input s_valid, s_col, s_frame, s_data, output s_ready);
endinterface

// File: rtl/cfg_phase_counter.sv
// Loadable down-counter that parks at zero; the zero flag marks the last cycle of a phase.
module cfg_phase_counter
  import frame_cfg_pkg::*;
(
  input  logic             CLK,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/frame_strobe_gen.sv
// Column frame writer: latches a frame word, then sequences setup / one-hot strobe / hold.
// state     | meaning
// ST_IDLE   | ready for a request; strobe low
// ST_SETUP  | FrameData stable, strobe low
// ST_STROBE | FrameStrobe[frame] high
// ST_HOLD   | FrameData stable, strobe low
module frame_strobe_gen
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int ColumnID        = 0,
  parameter int SetupCycles     = 1,
  parameter int StrobeCycles    = 1,
  parameter int HoldCycles      = 1
) (
  input  logic                       CLK,
  input  logic                       resetn,
  frame_strobe_gen_if.slave          s_if,
  input  logic                       err_clr,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err_addr
);
  if (SetupCycles < 1 || SetupCycles > 15 || StrobeCycles < 1 || StrobeCycles > 15 ||
      HoldCycles < 1 || HoldCycles > 15) begin : g_bad_phase
    $error("frame_strobe_gen: phase lengths must be 1..15");
  end
  if (MaxFramesPerCol < 1 || MaxFramesPerCol > 32) begin : g_bad_frames
    $error("frame_strobe_gen: MaxFramesPerCol must be 1..32");
  end

  localparam logic [ADDR_W-1:0]          COL_ID     = ADDR_W'(ColumnID);
  localparam logic [ADDR_W:0]            FRAME_LIM  = (ADDR_W+1)'(MaxFramesPerCol);
  localparam logic [CNT_W-1:0]           SETUP_LD   = phase_load(SetupCycles);
  localparam logic [CNT_W-1:0]           STROBE_LD  = phase_load(StrobeCycles);
  localparam logic [CNT_W-1:0]           HOLD_LD    = phase_load(HoldCycles);
  localparam logic [MaxFramesPerCol-1:0] STROBE_ONE = MaxFramesPerCol'(1);

  fsm_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]          frame_q, frame_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       err_q, err_d;
  logic                       accept, col_hit, in_range, err_set;
  logic                       cnt_load, cnt_zero;
  logic [CNT_W-1:0]           cnt_val;

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    data_d   = data_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_val  = SETUP_LD;
    accept   = s_if.s_valid && (state_q == ST_IDLE);
    col_hit  = accept && (s_if.s_col == COL_ID);
    in_range = ({1'b0, s_if.s_frame} < FRAME_LIM);
    err_set  = col_hit && !in_range;

    case (state_q)
      ST_IDLE: begin
        if (col_hit && in_range) begin
          state_d  = ST_SETUP;
          frame_d  = s_if.s_frame;
          data_d   = s_if.s_data;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d  = ST_STROBE;
          cnt_load = 1'b1;
          cnt_val  = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (cnt_zero) begin
          state_d  = ST_HOLD;
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobe is registered from the next state so it lines up with the STROBE phase.
    strobe_d = '0;
    if (state_d == ST_STROBE) begin
      strobe_d = STROBE_ONE << frame_d;
    end

    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      frame_q  <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  cfg_phase_counter u_phase_cnt (
    .CLK      (CLK),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign s_if.s_ready = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign FrameData    = data_q;
  assign FrameStrobe  = strobe_q;
  assign err_addr     = err_q;
endmodule

// File: tb/tb_frame_strobe_gen.sv
// Randomized bench for frame_strobe_gen against a timeline model of each accepted write.
module tb_frame_strobe_gen;
  localparam int S    = 2;
  localparam int T    = 3;
  localparam int H    = 1;
  localparam int COL  = 3;
  localparam int MAXF = 20;
  localparam int DW   = 32;

  logic            CLK = 1'b0;
  logic            resetn = 1'b1;
  logic            err_clr = 1'b0;
  logic [DW-1:0]   FrameData;
  logic [MAXF-1:0] FrameStrobe;
  logic            busy;
  logic            err_addr;

  frame_strobe_gen_if #(.FrameBitsPerRow(DW)) s_if ();

  frame_strobe_gen #(
    .MaxFramesPerCol (MAXF),
    .FrameBitsPerRow (DW),
    .ColumnID        (COL),
    .SetupCycles     (S),
    .StrobeCycles    (T),
    .HoldCycles      (H)
  ) dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .s_if        (s_if),
    .err_clr     (err_clr),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err_addr    (err_addr)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int cyc, t_acc, frm, n_acc, n_starts;
  logic [DW-1:0]   exp_data;
  logic            exp_err;
  logic            m_ready;
  logic [MAXF-1:0] prev_strobe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected outputs for the current cycle, derived from the accepted write's timeline.
  task automatic check_outputs();
    logic [MAXF-1:0] es;
    if (t_acc >= 0 && cyc >= t_acc + S + T + H + 1) t_acc = -1;
    m_ready = (t_acc < 0);
    es = '0;
    if (t_acc >= 0 && cyc >= t_acc + S + 1 && cyc <= t_acc + S + T) es[frm] = 1'b1;
    chk("s_ready", s_if.s_ready, m_ready);
    chk("busy", busy, !m_ready);
    chk("strobe", FrameStrobe, es);
    chk("data", FrameData, exp_data);
    chk("err_addr", err_addr, exp_err);
    chk("onehot", ($countones(FrameStrobe) <= 1), 1);
    if (FrameStrobe != '0 && prev_strobe == '0) n_starts++;
    prev_strobe = FrameStrobe;
  endtask

  task automatic step(input logic v, input logic [4:0] c, input logic [4:0] f,
                      input logic [DW-1:0] d, input logic clr);
    logic set;
    @(negedge CLK);
    check_outputs();
    s_if.s_valid = v;
    s_if.s_col   = c;
    s_if.s_frame = f;
    s_if.s_data  = d;
    err_clr      = clr;
    @(posedge CLK);
    cyc++;
    set = 1'b0;
    if (v && m_ready && c == 5'(COL)) begin
      if (int'(f) < MAXF) begin
        t_acc    = cyc - 1;
        frm      = int'(f);
        exp_data = d;
        n_acc++;
      end else begin
        set = 1'b1;
      end
    end
    if (set) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 5'($urandom), 5'($urandom), $urandom, 1'b0);
  endtask

  task automatic do_reset(input bit mid);
    @(negedge CLK);
    if (mid) check_outputs();
    s_if.s_valid = 1'b0;
    err_clr      = 1'b0;
    resetn       = 1'b0;
    #1;
    chk("rst_strobe", FrameStrobe, 0);
    chk("rst_data", FrameData, 0);
    chk("rst_err", err_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_if.s_ready, 1);
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    @(posedge CLK);
    cyc = 0; t_acc = -1; exp_data = '0; exp_err = 1'b0; m_ready = 1'b1; prev_strobe = '0;
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_col   = '0;
    s_if.s_frame = '0;
    s_if.s_data  = '0;
    cyc = 0; t_acc = -1; frm = 0; n_acc = 0; n_starts = 0;
    exp_data = '0; exp_err = 1'b0; m_ready = 1'b1; prev_strobe = '0;

    do_reset(1'b0);

    step(1'b1, 5'd3, 5'd7, 32'hDEADBEEF, 1'b0);
    repeat (S + T + H + 1) idle();
    step(1'b1, 5'd4, 5'd2, 32'h12345678, 1'b0);
    idle();
    step(1'b1, 5'd3, 5'd20, 32'h0BADF00D, 1'b0);
    idle();
    step(1'b0, 5'd0, 5'd0, 32'h0, 1'b1);
    idle();
    step(1'b1, 5'd3, 5'd20, 32'h0, 1'b0);
    step(1'b1, 5'd3, 5'd25, 32'h0, 1'b1);
    idle();
    step(1'b0, 5'd0, 5'd0, 32'h0, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      logic v, clr;
      logic [4:0] c, f;
      v   = ($urandom_range(0, 9) < 7);
      c   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(COL);
      f   = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(MAXF, 31))
                                        : 5'($urandom_range(0, MAXF - 1));
      clr = ($urandom_range(0, 9) == 0);
      step(v, c, f, $urandom, clr);
    end

    repeat (S + T + H + 2) idle();
    n_acc    = 0;
    n_starts = 0;
    for (int k = 0; k < 400 && n_acc < MAXF; k++) step(1'b1, 5'(COL), 5'(n_acc), $urandom, 1'b0);
    repeat (S + T + H + 2) idle();
    chk("b2b_strobes", n_starts, MAXF);

    step(1'b1, 5'(COL), 5'd11, $urandom, 1'b0);
    for (int k = 0; k < 20 && cyc < t_acc + S + 2; k++) idle();
    do_reset(1'b1);
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
